// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per clock,
// with a fixed WIDTH+2 cycle latency and HI/LO result registers read through a single port.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mdu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             read_req,
    input  logic             read_hi,
    output logic [WIDTH-1:0] read_data,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_count;
    logic [1:0]         r_op;
    logic               r_sign_a;
    logic               r_sign_b;
    logic [WIDTH:0]     r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_accept;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_fits;
    logic [WIDTH:0]     w_acc_nx;
    logic [WIDTH-1:0]   w_q_nx;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic               w_b_zero;

    // Operand signs only matter for the signed ops (mdu_op[0]==0); the most negative value
    // negates to itself and is then correctly read as an unsigned magnitude.
    assign w_accept = (r_state == S_IDLE) & start & ~flush;
    assign w_neg_a  = ~mdu_op[0] & operand_a[WIDTH-1];
    assign w_neg_b  = ~mdu_op[0] & operand_b[WIDTH-1];
    assign w_abs_a  = w_neg_a ? -operand_a : operand_a;
    assign w_abs_b  = w_neg_b ? -operand_b : operand_b;

    // Multiply: r_q holds the multiplier and shifts right as product bits fill in from the top.
    assign w_add    = r_q[0] ? (r_acc + {1'b0, r_b}) : r_acc;

    // Divide: r_q holds the dividend and shifts left as quotient bits fill in from the bottom.
    assign w_shift  = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_b};
    assign w_fits   = ~w_diff[WIDTH];

    assign w_acc_nx = r_op[1] ? (w_fits ? w_diff : w_shift) : {1'b0, w_add[WIDTH:1]};
    assign w_q_nx   = r_op[1] ? {r_q[WIDTH-2:0], w_fits} : {w_add[0], r_q[WIDTH-1:1]};

    assign w_prod     = {r_acc[WIDTH-1:0], r_q};
    assign w_prod_fix = (r_sign_a ^ r_sign_b) ? -w_prod : w_prod;
    assign w_quo      = (r_sign_a ^ r_sign_b) ? -r_q : r_q;
    assign w_rem      = r_sign_a ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_b_zero   = (r_b == '0);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: next state is defaulted first so no path through the case can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_RUN;
            S_RUN: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (r_count == CW'(1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= mdu_op;
                        r_sign_a <= w_neg_a;
                        r_sign_b <= w_neg_b;
                        r_acc    <= '0;
                        r_q      <= mdu_op[1] ? w_abs_a : w_abs_b;
                        r_b      <= mdu_op[1] ? w_abs_b : w_abs_a;
                        r_count  <= CW'(WIDTH);
                        r_dbz    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        r_count <= '0;
                    end else begin
                        r_acc   <= w_acc_nx;
                        r_q     <= w_q_nx;
                        r_count <= r_count - CW'(1);
                    end
                end
                S_FIX: begin
                    // A flush arriving with the final edge cancels the write-back entirely.
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_op[1] && w_b_zero) begin
                            r_dbz <= 1'b1;
                        end else if (r_op[1]) begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == S_RUN) | (r_state == S_FIX);
    assign stall       = busy & (start | read_req);
    assign done        = r_done;
    assign div_by_zero = r_dbz;
    assign read_data   = read_hi ? r_hi : r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: a latency-countdown model with plain 64-bit arithmetic checked every
// cycle, plus directed operations with hand-computed HI/LO, timing and flag expectations.
module tb_mdu_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mdu_op = 2'b00;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         flush = 1'b0;
    logic         read_req = 1'b0;
    logic         read_hi = 1'b0;
    logic [W-1:0] read_data;
    logic         busy;
    logic         stall;
    logic         done;
    logic         div_by_zero;

    mdu_sequencer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mdu_op      (mdu_op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .flush       (flush),
        .read_req    (read_req),
        .read_hi     (read_hi),
        .read_data   (read_data),
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         zero;
    } res_t;

    function automatic res_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t            r;
        longint          sa;
        longint          sb;
        longint          p;
        longint          q;
        longint          m;
        longint unsigned up;
        r  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin
                p    = sa * sb;
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            2'b01: begin
                up   = {32'b0, a} * {32'b0, b};
                r.hi = up[63:32];
                r.lo = up[31:0];
            end
            2'b10: begin
                if (b == '0) begin
                    r.zero = 1'b1;
                end else begin
                    q    = sa / sb;
                    m    = sa % sb;
                    r.lo = q[31:0];
                    r.hi = m[31:0];
                end
            end
            default: begin
                if (b == '0) begin
                    r.zero = 1'b1;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    // Model: an accepted start yields W+1 busy cycles, then results land with a one-cycle done.
    int           m_left = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dbz = 1'b0;
    logic         m_done = 1'b0;
    res_t         m_res = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_dbz  <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left != 0) begin
                if (flush) begin
                    m_left <= 0;
                end else if (m_left == 1) begin
                    m_left <= 0;
                    m_done <= 1'b1;
                    if (m_res.zero) begin
                        m_dbz <= 1'b1;
                    end else begin
                        m_hi <= m_res.hi;
                        m_lo <= m_res.lo;
                    end
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start && !flush) begin
                m_res  <= model(mdu_op, operand_a, operand_b);
                m_left <= W + 1;
                m_dbz  <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        check("cmp busy", busy, m_left != 0);
        check("cmp stall", stall, (m_left != 0) && (start || read_req));
        check("cmp done", done, m_done);
        check("cmp div_by_zero", div_by_zero, m_dbz);
        check("cmp read_data", read_data, read_hi ? m_hi : m_lo);
    end

    task automatic drive_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        mdu_op    = op;
        operand_a = a;
        operand_b = b;
    endtask

    // Caller has driven start in cycle 0; cycles 1..limit are followed here.
    task automatic track(input string name, input int limit, input int flush_at, input int intrude_at,
                         input int exp_done, input int exp_busy);
        int done_cyc = 0;
        int busy_cnt = 0;
        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            start    = 1'b0;
            read_req = 1'b0;
            flush    = (cyc == flush_at);
            if (cyc == intrude_at) begin
                start    = 1'b1;
                read_req = 1'b1;
                mdu_op   = ~mdu_op;
            end
            #3;
            if (busy) busy_cnt++;
            if (done && done_cyc == 0) done_cyc = cyc;
            if (cyc == 1) check({name, " flag cleared by start"}, div_by_zero, 1'b0);
            if (cyc == intrude_at) check({name, " stall"}, stall, 1'b1);
            if (flush_at != 0 && cyc == flush_at + 1) check({name, " busy after flush"}, busy, 1'b0);
        end
        flush = 1'b0;
        check({name, " done cycle"}, done_cyc, exp_done);
        check({name, " busy cycles"}, busy_cnt, exp_busy);
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int flush_at, input int intrude_at, input int exp_done, input int exp_busy);
        @(negedge clk);
        drive_start(op, a, b);
        track(name, 40, flush_at, intrude_at, exp_done, exp_busy);
    endtask

    task automatic chk_hilo(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo);
        #1;
        read_req = 1'b1;
        read_hi  = 1'b1;
        #1;
        check({name, " HI"}, read_data, hi);
        check({name, " idle read stall"}, stall, 1'b0);
        read_hi = 1'b0;
        #1;
        check({name, " LO"}, read_data, lo);
        read_req = 1'b0;
    endtask

    initial begin
        int done_seen;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        check("reset busy", busy, 1'b0);
        check("reset read_data", read_data, '0);
        check("reset div_by_zero", div_by_zero, 1'b0);

        // First start right as reset releases.
        @(negedge clk);
        reset = 1'b0;
        drive_start(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        track("mult -3x7", 40, 0, 0, 34, 33);
        chk_hilo("mult -3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 34, 33);
        chk_hilo("multu max", 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult -1x-1", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 34, 33);
        chk_hilo("mult -1x-1", 32'h0000_0000, 32'h0000_0001);

        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0, 34, 33);
        chk_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 7/2", 2'b11, 32'h0000_0007, 32'h0000_0002, 0, 0, 34, 33);
        chk_hilo("divu 7/2", 32'h0000_0001, 32'h0000_0003);
        run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 34, 33);
        chk_hilo("div min/-1", 32'h0000_0000, 32'h8000_0000);
        check("div min/-1 no flag", div_by_zero, 1'b0);

        run_op("divu 0x451/0x20", 2'b11, 32'h0000_0451, 32'h0000_0020, 0, 0, 34, 33);
        chk_hilo("divu 0x451/0x20", 32'h0000_0011, 32'h0000_0022);
        run_op("divu 5/0", 2'b11, 32'h0000_0005, 32'h0000_0000, 0, 0, 34, 33);
        check("divu 5/0 flag", div_by_zero, 1'b1);
        chk_hilo("divu 5/0", 32'h0000_0011, 32'h0000_0022);
        run_op("multu 6x7", 2'b01, 32'h0000_0006, 32'h0000_0007, 0, 0, 34, 33);
        chk_hilo("multu 6x7", 32'h0000_0000, 32'h0000_002A);

        // Start and read_req during RUN stall and are ignored; the original mult completes.
        run_op("mult intrude", 2'b00, 32'hFFFF_FFF6, 32'h0000_0005, 0, 5, 34, 33);
        chk_hilo("mult intrude", 32'hFFFF_FFFF, 32'hFFFF_FFCE);
        run_op("flush run", 2'b01, 32'h0000_1234, 32'h0000_0010, 10, 0, 0, 10);
        chk_hilo("flush run", 32'hFFFF_FFFF, 32'hFFFF_FFCE);
        run_op("flush fix", 2'b11, 32'h0000_0064, 32'h0000_0007, 33, 0, 0, 33);
        chk_hilo("flush fix", 32'hFFFF_FFFF, 32'hFFFF_FFCE);

        // Back-to-back: the second start is driven in the done cycle of the first.
        @(negedge clk);
        drive_start(2'b11, 32'h0000_0064, 32'h0000_0007);
        track("chain divu", 34, 0, 0, 34, 33);
        chk_hilo("chain divu", 32'h0000_0002, 32'h0000_000E);
        drive_start(2'b00, 32'h0000_0003, 32'hFFFF_FFFE);
        track("chain mult", 40, 0, 0, 34, 33);
        chk_hilo("chain mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // Asynchronous reset in the middle of cycle 15 of a mult.
        @(negedge clk);
        drive_start(2'b00, 32'h0000_0005, 32'h0000_0006);
        for (int cyc = 1; cyc <= 15; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1 reset = 1'b1;
        #2;
        check("async reset busy", busy, 1'b0);
        check("async reset done", done, 1'b0);
        read_hi = 1'b1;
        #1;
        check("async reset HI", read_data, '0);
        read_hi = 1'b0;
        #1;
        check("async reset LO", read_data, '0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            #3;
            if (done || busy) done_seen++;
        end
        check("after reset no done/busy", done_seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width; the iteration count equals WIDTH.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request to start the operation given by mdu_op.
REQ-006 mdu_op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 operand_a  input  WIDTH  rs value after forwarding (multiplicand or dividend).
REQ-008 operand_b  input  WIDTH  rt value after forwarding (multiplier or divisor).
REQ-009 flush  input  1  cancels any in-flight operation.
REQ-010 read_req  input  1  mfhi/mflo is in EX.
REQ-011 read_hi  input  1  read select: 1 selects HI, 0 selects LO.
REQ-012 read_data  output  WIDTH  HI or LO per read_hi; combinational from the registers.
REQ-013 busy  output  1  operation in progress.
REQ-014 stall  output  1  pipeline hold request.
REQ-015 done  output  1  one-cycle pulse when HI/LO are updated or a divide-by-zero completes.
REQ-016 div_by_zero  output  1  sticky flag; last accepted divide had operand_b equal to 0.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and FIX; busy SHALL be 1 exactly in RUN and FIX.
REQ-018 In IDLE, a cycle with start=1 and flush=0 SHALL be accepted at the clock edge (E0).
REQ-019 At E0 the block SHALL capture mdu_op, |operand_a|, |operand_b| and both operand signs, load count=WIDTH and enter RUN.
- Absolute value applies only to mult and div.
- |0x80000000| is 0x80000000, treated as unsigned.
REQ-020 RUN SHALL perform one iteration per edge and decrement count.
- mult/multu: shift-add, one multiplier bit per edge.
- div/divu: restoring division, one quotient bit per edge.
REQ-021 After WIDTH iterations (edges E1..E_WIDTH) the FSM SHALL enter FIX.
REQ-022 At edge E_WIDTH+1 in FIX the block SHALL apply the sign correction, write HI/LO, pulse done for the following cycle, and return to IDLE.
REQ-023 Total latency SHALL be fixed: done=1 and new HI/LO readable in cycle WIDTH+2 after the start cycle (cycle 34 for WIDTH=32), independent of operand values.
REQ-024 Sign correction SHALL be:
- mult: {HI,LO} = 2*WIDTH-bit product, negated if operand signs differ.
- div: LO = quotient, negated if operand signs differ; HI = remainder, carrying the dividend's sign.
- multu/divu: no correction.
REQ-025 Signed div of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 (wrap, no flag).
REQ-026 Divide with operand_b=0 SHALL:
- run the full latency;
- set div_by_zero=1 in the done cycle;
- leave HI/LO unchanged.
REQ-027 div_by_zero SHALL clear on the next accepted start.
REQ-028 stall SHALL equal busy & (start | read_req).
REQ-029 A start while busy SHALL be ignored; the requester holds start until acceptance.
REQ-030 A start in the done cycle SHALL be accepted (the state is IDLE).
REQ-031 read_req in IDLE SHALL return the current HI/LO with no stall.
REQ-032 flush=1 in RUN or FIX SHALL force IDLE at the next edge, leave HI/LO and div_by_zero unchanged, and produce no done.
REQ-033 flush=1 in IDLE SHALL block acceptance of a simultaneous start.
REQ-034 flush and the FIX-to-IDLE transition on the same edge: flush SHALL win and HI/LO SHALL NOT be written.

Reset
REQ-035 reset=1 SHALL immediately force all outputs and state to their reset values, regardless of the clock:
- state=IDLE, count=0, HI=0, LO=0;
- busy=0, stall=0, done=0, div_by_zero=0.
- An in-flight operation is discarded.
REQ-036 After reset deassertion, the first start SHALL be accepted on the next rising edge.

Verification
REQ-037 The bench SHALL cover: mult 0xFFFFFFFD x 0x00000007 -> busy cycles 1..33, done at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-038 The bench SHALL cover: multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; then mult of the same operands -> HI=0, LO=1.
REQ-039 The bench SHALL cover: div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-040 The bench SHALL cover: with HI=0x11, LO=0x22, divu 5/0 -> done at cycle 34, div_by_zero=1, HI=0x11, LO=0x22; the next start clears the flag.
REQ-041 The bench SHALL cover: start and read_req asserted during RUN -> stall=1 and the start is ignored; flush at cycle 10 -> busy=0 at cycle 11, no done, HI/LO unchanged.
REQ-042 The bench SHALL cover: reset asserted mid-cycle at cycle 15 of a mult -> busy=0, HI=LO=0 before the next edge; done is never asserted.
